// File: rtl/digitron_scan_decoder.sv
// ---------------------------------------------------------------------------
// digitron_scan_decoder
//
// Receive side of a multiplexed seven-segment display link. It watches the
// segment bus together with the active-low digit selects, and waits until a
// (select, segment) pair has stayed unchanged long enough before accepting
// it. Each accepted pair is decoded back to BCD. The block collects slot 0
// (TimerL), slot 1 (TimerH) and slot 2 (Player_Number) into shadow registers
// and publishes a complete frame with a one-cycle Frame_Valid strobe.
//
// Parameters
//   STABLE_CNT    : number of consecutive sampling edges before a pair is
//                   accepted (2..255)
//   FRAME_TIMEOUT : number of edges without a completed frame before
//                   Link_Lost asserts (16-bit)
//
// Ports
//   CLK           in   system clock; every register uses the rising edge
//   RSTn          in   synchronous active-low reset
//   Digitron_In   in   segment bus, bit0=a .. bit6=g, bit7=dp (ignored)
//   DigitronCS_In in   digit select, active-low, one-cold
//   Player_Number out  decoded slot-2 digit of the last complete frame
//   TimerH        out  decoded slot-1 digit of the last complete frame
//   TimerL        out  decoded slot-0 digit of the last complete frame
//   Frame_Valid   out  one-cycle pulse when the outputs load a new frame
//   Seg_Error     out  one-cycle pulse when an undecodable pattern is accepted
//   Link_Lost     out  level; no frame has completed for FRAME_TIMEOUT edges
// ---------------------------------------------------------------------------
module digitron_scan_decoder #(
  parameter int unsigned STABLE_CNT    = 4,
  parameter int unsigned FRAME_TIMEOUT = 2047
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [7:0] Digitron_In,
  input  logic [3:0] DigitronCS_In,
  output logic [3:0] Player_Number,
  output logic [3:0] TimerH,
  output logic [3:0] TimerL,
  output logic       Frame_Valid,
  output logic       Seg_Error,
  output logic       Link_Lost
);

  // Acceptance happens on the edge at which the dwell count would reach
  // STABLE_CNT, so the register is compared against STABLE_CNT-1.
  localparam logic [7:0]  STABLE_LAST   = 8'(STABLE_CNT - 1);
  localparam logic [15:0] TIMEOUT_MAX   = 16'(FRAME_TIMEOUT);
  localparam logic [15:0] TIMEOUT_PRE   = 16'(FRAME_TIMEOUT - 1);
  localparam logic [6:0]  BLANK_PATTERN = 7'h3F;
  localparam int          NUM_DATA      = 3;
  localparam logic [1:0]  BLANK_SLOT    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HELD
  } state_t;

  // -------------------------------------------------------------------------
  // Decode helpers
  // -------------------------------------------------------------------------

  // Returns {valid, slot}. Only one-cold selects map to a slot.
  function automatic logic [2:0] decode_select(input logic [3:0] cs);
    logic [2:0] res;
    res = 3'b000;
    case (cs)
      4'b1110: res = {1'b1, 2'd0};
      4'b1101: res = {1'b1, 2'd1};
      4'b1011: res = {1'b1, 2'd2};
      4'b0111: res = {1'b1, 2'd3};
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  // Returns {valid, bcd}. Only the ten canonical digit shapes are legal.
  function automatic logic [4:0] decode_segments(input logic [6:0] seg);
    logic [4:0] res;
    res = 5'b0_0000;
    case (seg)
      7'h3F: res = {1'b1, 4'd0};
      7'h06: res = {1'b1, 4'd1};
      7'h5B: res = {1'b1, 4'd2};
      7'h4F: res = {1'b1, 4'd3};
      7'h66: res = {1'b1, 4'd4};
      7'h6D: res = {1'b1, 4'd5};
      7'h7D: res = {1'b1, 4'd6};
      7'h07: res = {1'b1, 4'd7};
      7'h7F: res = {1'b1, 4'd8};
      7'h6F: res = {1'b1, 4'd9};
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [1:0]  slot_q, slot_d;        // latched slot of the current dwell
  logic [6:0]  seg_q, seg_d;          // latched pattern of the current dwell
  logic [7:0]  dwell_q, dwell_d;      // edges the latched pair has persisted
  logic [2:0]  seen_q, seen_d;        // slots accepted since the last frame
  logic [11:0] shadow_q, shadow_d;    // per-slot digits, 4 bits each
  logic [11:0] frame_q, frame_d;      // published frame, 4 bits per slot
  logic [15:0] tmo_q, tmo_d;          // edges since the last completed frame
  logic        frame_valid_q, frame_valid_d;
  logic        seg_error_q, seg_error_d;
  logic        link_lost_q, link_lost_d;

  // The decimal point carries no information for this link.
  logic unused_dp;
  assign unused_dp = Digitron_In[7];

  // -------------------------------------------------------------------------
  // Input pair decode
  // -------------------------------------------------------------------------
  logic [2:0] cur_sel;
  logic       cur_valid;
  logic [1:0] cur_slot;
  logic [6:0] cur_seg;
  logic       pair_match;

  assign cur_sel    = decode_select(DigitronCS_In);
  assign cur_valid  = cur_sel[2];
  assign cur_slot   = cur_sel[1:0];
  assign cur_seg    = Digitron_In[6:0];
  assign pair_match = (cur_slot == slot_q) && (cur_seg == seg_q);

  // -------------------------------------------------------------------------
  // Dwell FSM
  // -------------------------------------------------------------------------
  logic accept;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    seg_d   = seg_q;
    dwell_d = dwell_q;
    accept  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cur_valid) begin
          state_d = S_SETTLE;
          slot_d  = cur_slot;
          seg_d   = cur_seg;
          dwell_d = 8'd1;
        end
      end

      S_SETTLE: begin
        if (!cur_valid) begin
          state_d = S_IDLE;
          dwell_d = 8'd0;
        end else if (pair_match) begin
          if (dwell_q == STABLE_LAST) begin
            // The pair has now been seen on STABLE_CNT consecutive edges.
            accept  = 1'b1;
            state_d = S_HELD;
            dwell_d = dwell_q + 8'd1;
          end else begin
            dwell_d = dwell_q + 8'd1;
          end
        end else begin
          slot_d  = cur_slot;
          seg_d   = cur_seg;
          dwell_d = 8'd1;
        end
      end

      S_HELD: begin
        // The dwell was already accepted; only a change restarts the count.
        if (!cur_valid) begin
          state_d = S_IDLE;
          dwell_d = 8'd0;
        end else if (!pair_match) begin
          state_d = S_SETTLE;
          slot_d  = cur_slot;
          seg_d   = cur_seg;
          dwell_d = 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        dwell_d = 8'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Acceptance decode. At an acceptance edge the live pair equals the latch,
  // so the latched copy is used to keep this path off the input pins.
  // -------------------------------------------------------------------------
  logic [4:0] acc_dec;
  logic       acc_digit_ok;
  logic [3:0] acc_digit;
  logic       acc_data_slot;
  logic       digit_write;
  logic       seg_bad_data;
  logic       seg_bad_blank;

  assign acc_dec       = decode_segments(seg_q);
  assign acc_digit_ok  = acc_dec[4];
  assign acc_digit     = acc_dec[3:0];
  assign acc_data_slot = (slot_q != BLANK_SLOT);
  assign digit_write   = accept && acc_data_slot && acc_digit_ok;
  assign seg_bad_data  = accept && acc_data_slot && !acc_digit_ok;
  // The blank slot is only a sanity check on the scan: it must show "0".
  assign seg_bad_blank = accept && !acc_data_slot && (seg_q != BLANK_PATTERN);

  // -------------------------------------------------------------------------
  // Per-slot shadow, seen and output loading
  // -------------------------------------------------------------------------
  logic [2:0] seen_set;
  logic [2:0] seen_clr;
  logic       frame_done;

  // Completion looks at the seen bits from before this edge, so a timeout
  // landing on the same edge cannot prevent the frame from completing.
  assign frame_done = digit_write && ((seen_q | seen_set) == 3'b111);

  for (genvar gi = 0; gi < NUM_DATA; gi++) begin : g_slot
    logic slot_hit;
    assign slot_hit     = accept && (slot_q == 2'(gi));
    assign seen_set[gi] = slot_hit && acc_digit_ok;
    assign seen_clr[gi] = slot_hit && !acc_digit_ok;

    assign shadow_d[gi*4 +: 4] = seen_set[gi] ? acc_digit : shadow_q[gi*4 +: 4];

    // The digit accepted on the completing edge bypasses its shadow.
    assign frame_d[gi*4 +: 4]  = frame_done ? shadow_d[gi*4 +: 4]
                                            : frame_q[gi*4 +: 4];
  end

  // -------------------------------------------------------------------------
  // Frame timeout and seen bookkeeping
  // -------------------------------------------------------------------------
  logic       timeout_hit;
  logic [2:0] seen_base;

  // Fires only on the edge the counter reaches the limit, not while it sits
  // saturated; otherwise the seen bits could never accumulate after a stall.
  assign timeout_hit = !frame_done && (tmo_q == TIMEOUT_PRE);

  always_comb begin
    seen_base = seen_q;
    seen_d    = seen_q;
    tmo_d     = tmo_q;

    if (frame_done) begin
      seen_d = 3'b000;
      tmo_d  = 16'd0;
    end else begin
      // A digit accepted on the timeout edge is fresh and survives the clear.
      seen_base = timeout_hit ? 3'b000 : seen_q;
      seen_d    = (seen_base | seen_set) & ~seen_clr;
      if (tmo_q != TIMEOUT_MAX) begin
        tmo_d = tmo_q + 16'd1;
      end
    end
  end

  always_comb begin
    link_lost_d = link_lost_q;
    if (frame_done) begin
      link_lost_d = 1'b0;
    end else if (timeout_hit) begin
      link_lost_d = 1'b1;
    end
  end

  assign frame_valid_d = frame_done;
  assign seg_error_d   = seg_bad_data || seg_bad_blank;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q       <= S_IDLE;
      slot_q        <= 2'd0;
      seg_q         <= 7'd0;
      dwell_q       <= 8'd0;
      seen_q        <= 3'b000;
      shadow_q      <= 12'd0;
      frame_q       <= 12'd0;
      tmo_q         <= 16'd0;
      frame_valid_q <= 1'b0;
      seg_error_q   <= 1'b0;
      link_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      seg_q         <= seg_d;
      dwell_q       <= dwell_d;
      seen_q        <= seen_d;
      shadow_q      <= shadow_d;
      frame_q       <= frame_d;
      tmo_q         <= tmo_d;
      frame_valid_q <= frame_valid_d;
      seg_error_q   <= seg_error_d;
      link_lost_q   <= link_lost_d;
    end
  end

  assign TimerL        = frame_q[3:0];
  assign TimerH        = frame_q[7:4];
  assign Player_Number = frame_q[11:8];
  assign Frame_Valid   = frame_valid_q;
  assign Seg_Error     = seg_error_q;
  assign Link_Lost     = link_lost_q;

endmodule

// File: tb/tb_digitron_scan_decoder.sv
// Testbench for digitron_scan_decoder: directed scenarios followed by
// randomized scan traffic, all checked every cycle against a run-length
// reference model of the receive link.
module tb_digitron_scan_decoder;

  localparam int STABLE = 4;
  localparam int TMO    = 2047;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic [7:0] Digitron_In;
  logic [3:0] DigitronCS_In;
  logic [3:0] Player_Number;
  logic [3:0] TimerH;
  logic [3:0] TimerL;
  logic       Frame_Valid;
  logic       Seg_Error;
  logic       Link_Lost;

  always #5 CLK = ~CLK;

  digitron_scan_decoder #(
    .STABLE_CNT   (STABLE),
    .FRAME_TIMEOUT(TMO)
  ) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .Digitron_In  (Digitron_In),
    .DigitronCS_In(DigitronCS_In),
    .Player_Number(Player_Number),
    .TimerH       (TimerH),
    .TimerL       (TimerL),
    .Frame_Valid  (Frame_Valid),
    .Seg_Error    (Seg_Error),
    .Link_Lost    (Link_Lost)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a pair is accepted when it has been present on exactly
  // STABLE consecutive edges; frame bookkeeping follows the link rules.
  // --------------------------------------------------------------------------
  logic [6:0] seg_table [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [3:0] sel_table [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  int         m_run;
  logic [3:0] m_prev_cs;
  logic [6:0] m_prev_seg;
  bit         m_seen   [3];
  logic [3:0] m_shadow [3];
  logic [3:0] m_out    [3];
  bit         m_fv, m_se, m_ll;
  int         m_tmo;

  int fv_seen = 0;
  int se_seen = 0;
  int cycle   = 0;

  function automatic int slot_of(input logic [3:0] cs);
    for (int k = 0; k < 4; k++) if (sel_table[k] == cs) return k;
    return -1;
  endfunction

  function automatic int digit_of(input logic [6:0] seg);
    for (int k = 0; k < 10; k++) if (seg_table[k] == seg) return k;
    return -1;
  endfunction

  task automatic model_edge(input logic [3:0] cs, input logic [6:0] seg, input bit rstn);
    int s;
    int d;
    bit acc;
    bit complete;
    bit all_seen;
    m_fv = 0;
    m_se = 0;
    if (!rstn) begin
      m_run = 0; m_prev_cs = 4'hF; m_prev_seg = 7'h0;
      for (int k = 0; k < 3; k++) begin
        m_seen[k] = 0; m_shadow[k] = 4'd0; m_out[k] = 4'd0;
      end
      m_ll = 0; m_tmo = 0;
      return;
    end
    s = slot_of(cs);
    if (s < 0) m_run = 0;
    else if (m_run > 0 && cs == m_prev_cs && seg == m_prev_seg) begin
      if (m_run < 1000) m_run++;
    end else m_run = 1;
    m_prev_cs  = cs;
    m_prev_seg = seg;

    acc      = (s >= 0) && (m_run == STABLE);
    complete = 0;
    d        = -1;
    if (acc) begin
      d = digit_of(seg);
      if (s == 3) m_se = (seg != 7'h3F);
      else if (d < 0) m_se = 1;
      else begin
        m_shadow[s] = d[3:0];
        all_seen = 1;
        for (int k = 0; k < 3; k++) if (k != s && !m_seen[k]) all_seen = 0;
        complete = all_seen;
      end
    end

    if (complete) begin
      for (int k = 0; k < 3; k++) begin
        m_out[k] = m_shadow[k]; m_seen[k] = 0;
      end
      m_fv = 1; m_ll = 0; m_tmo = 0;
    end else begin
      if (m_tmo < TMO) begin
        m_tmo++;
        if (m_tmo == TMO) begin
          m_ll = 1;
          for (int k = 0; k < 3; k++) m_seen[k] = 0;
        end
      end
      if (acc && s < 3) m_seen[s] = (d >= 0);
    end
  endtask

  // One clock: drive, advance model at the edge, compare just after it.
  task automatic step(input logic [3:0] cs, input logic [7:0] seg, input bit rstn);
    DigitronCS_In = cs;
    Digitron_In   = seg;
    RSTn          = rstn;
    @(posedge CLK);
    model_edge(cs, seg[6:0], rstn);
    #1;
    cycle++;
    check_eq("timer_l",     16'(TimerL),        16'(m_out[0]));
    check_eq("timer_h",     16'(TimerH),        16'(m_out[1]));
    check_eq("player",      16'(Player_Number), 16'(m_out[2]));
    check_eq("frame_valid", 16'(Frame_Valid),   16'(m_fv));
    check_eq("seg_error",   16'(Seg_Error),     16'(m_se));
    check_eq("link_lost",   16'(Link_Lost),     16'(m_ll));
    if (Frame_Valid) begin
      fv_seen++;
      $display("[TB] cycle %0d frame L=%0d H=%0d P=%0d", cycle, TimerL, TimerH, Player_Number);
    end
    if (Seg_Error) begin
      se_seen++;
      $display("[TB] cycle %0d seg_error pulse", cycle);
    end
  endtask

  task automatic dwell(input logic [3:0] cs, input logic [7:0] seg, input int n);
    for (int i = 0; i < n; i++) step(cs, seg, 1'b1);
  endtask

  initial begin
    int fv0;
    int se0;
    int len;
    int r;
    int sidx;
    logic [3:0] cs;
    logic [7:0] seg;
    bit do_rst;

    // Reset during random bus activity.
    step(4'($urandom), 8'($urandom), 1'b0);
    step(4'($urandom), 8'($urandom), 1'b0);
    check_eq("reset_outputs", 16'({Player_Number, TimerH, TimerL}), 16'h000);
    check_eq("reset_flags",   16'({Frame_Valid, Seg_Error, Link_Lost}), 16'h0);

    // Nominal frame; Frame_Valid on the STABLE-th edge of the slot-2 dwell.
    dwell(4'b1110, 8'h07, 10);
    dwell(4'b1101, 8'h4F, 10);
    for (int i = 0; i < 10; i++) begin
      step(4'b1011, 8'h6D, 1'b1);
      check_eq("nominal_fv_timing", 16'(Frame_Valid), 16'(i == STABLE - 1));
    end
    dwell(4'b0111, 8'h3F, 10);
    check_eq("nominal_digits", 16'({Player_Number, TimerH, TimerL}), 16'h537);
    check_eq("nominal_no_seg_err", 16'(se_seen), 16'd0);

    // Short glitch in slot 1 must not replace the full-length dwell value.
    dwell(4'b1110, 8'h07, 10);
    dwell(4'b1101, 8'h06, 10);
    dwell(4'b1101, 8'h5B, 3);
    dwell(4'b1011, 8'h6D, 10);
    dwell(4'b0111, 8'h3F, 10);
    check_eq("glitch_timer_h", 16'(TimerH), 16'd1);
    check_eq("glitch_no_seg_err", 16'(se_seen), 16'd0);

    // Invalid slot-1 pattern blocks the frame until slot 1 is valid again.
    fv0 = fv_seen;
    se0 = se_seen;
    dwell(4'b1110, 8'h07, 10);
    dwell(4'b1101, 8'h00, 10);
    check_eq("invalid_seg_err_count", 16'(se_seen - se0), 16'd1);
    dwell(4'b1011, 8'h6D, 10);
    check_eq("invalid_no_frame", 16'(fv_seen - fv0), 16'd0);
    dwell(4'b1101, 8'h4F, 10);
    check_eq("invalid_frame_after_fix", 16'(fv_seen - fv0), 16'd1);
    check_eq("invalid_digits", 16'({Player_Number, TimerH, TimerL}), 16'h537);

    // Stall: no selects for FRAME_TIMEOUT edges, outputs must hold.
    for (int i = 0; i < TMO; i++) step(4'hF, 8'($urandom), 1'b1);
    check_eq("stall_link_lost", 16'(Link_Lost), 16'd1);
    check_eq("stall_hold", 16'({Player_Number, TimerH, TimerL}), 16'h537);
    dwell(4'b1110, 8'h7D, 10);
    dwell(4'b1101, 8'h06, 10);
    for (int i = 0; i < 10; i++) begin
      step(4'b1011, 8'h66, 1'b1);
      if (i == STABLE - 1) begin
        check_eq("resume_fv", 16'(Frame_Valid), 16'd1);
        check_eq("resume_ll_clear", 16'(Link_Lost), 16'd0);
      end else if (i < STABLE - 1) begin
        check_eq("resume_ll_held", 16'(Link_Lost), 16'd1);
      end
    end
    check_eq("resume_digits", 16'({Player_Number, TimerH, TimerL}), 16'h416);

    // Reset mid-frame discards accepted slots 0 and 1.
    dwell(4'b0111, 8'h3F, 10);
    dwell(4'b1110, 8'h07, 10);
    dwell(4'b1101, 8'h4F, 10);
    step(4'b1101, 8'h4F, 1'b0);
    fv0 = fv_seen;
    dwell(4'b1011, 8'h6D, 20);
    check_eq("midreset_no_frame", 16'(fv_seen - fv0), 16'd0);
    dwell(4'b1110, 8'h06, 10);
    dwell(4'b1101, 8'h5B, 10);
    check_eq("midreset_frame", 16'(fv_seen - fv0), 16'd1);
    check_eq("midreset_digits", 16'({Player_Number, TimerH, TimerL}), 16'h521);

    // Randomized scan-like traffic with short dwells, bad codes and resets.
    sidx = 0;
    for (int n = 0; n < 500; n++) begin
      len = $urandom_range(1, 14);
      r   = $urandom_range(0, 99);
      if (r < 70) begin
        cs   = sel_table[sidx];
        sidx = (sidx + 1) % 4;
      end else if (r < 85) begin
        cs = sel_table[$urandom_range(0, 3)];
      end else if (r < 93) begin
        cs = 4'hF;
      end else begin
        cs = 4'($urandom);
      end
      if ($urandom_range(0, 99) < 85) seg = {1'($urandom), seg_table[$urandom_range(0, 9)]};
      else                            seg = 8'($urandom);
      if (cs == 4'b0111 && $urandom_range(0, 99) < 70) seg = {1'($urandom), 7'h3F};
      do_rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < len; i++) step(cs, seg, !(do_rst && i == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
